// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the serial joystick front end.
// Contents: FSM state enum, joystick field positions/width, released-pad value.
package joy_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam int unsigned J1_LSB = 0;
  localparam int unsigned J2_LSB = 8;
  localparam int unsigned JW     = 6;

  localparam logic [JW-1:0] RELEASED = 6'h3F;

endpackage

// File: rtl/joy_serial_if.sv
// Board-side bundle of the serial joystick front end.
// Signals: joyD (serial data in), joyCk/joyLd (shift register clock/load_n),
//          joy1/joy2 (active-low pad words), strb (frame-end pulse).
// Modports: master = joy_serial, slave = shift register / consumer side.
interface joy_serial_if;
  import joy_pkg::*;

  logic          joyD;
  logic          joyCk;
  logic          joyLd;
  logic [JW-1:0] joy1;
  logic [JW-1:0] joy2;
  logic          strb;

  modport master (input joyD, output joyCk, joyLd, joy1, joy2, strb);
  modport slave  (output joyD, input joyCk, joyLd, joy1, joy2, strb);

endinterface

// File: rtl/joy_serial_tick.sv
// joy_tick: divides clock-enable pulses down to the shift tick.
// Ports: clock, reset (async active-low), ce (count enable), tick (ce on the
//        last count of each CKDIV-long group).
module joy_tick #(
  parameter int unsigned CKDIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  output logic tick
);

  localparam int unsigned DW = (CKDIV > 1) ? $clog2(CKDIV) : 1;

  logic [DW-1:0] div;
  logic          at_top_c;

  assign at_top_c = (div == DW'(CKDIV - 1));
  assign tick     = ce & at_top_c;

  // ce-qualified modulo-CKDIV counter; holds while ce is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (ce) begin
      div <= at_top_c ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/joy_serial.sv
// joy_serial: drives an external parallel-in shift register, reads one
// NBITS frame serially and presents two active-low 6-bit joystick words.
// Ports: clock, reset (async active-low), ce (clock enable),
//        bus (joy_serial_if.master: joyD in; joyCk, joyLd, joy1, joy2, strb out).
// Optional: define JOY_DEBOUNCE_EN to commit a frame only when it matches
//           the previous one (two identical consecutive frames).
module joy_serial
  import joy_pkg::*;
#(
  parameter int unsigned CKDIV = 4,
  parameter int unsigned NBITS = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  joy_serial_if.master bus
);

  localparam int unsigned BW = $clog2(NBITS);

  state_t           state, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] sr, sr_d;
  logic             ck_q, ck_d;
  logic             ld_q, ld_d;
  logic             strb_q, strb_d;
  logic [JW-1:0]    j1_q, j1_d;
  logic [JW-1:0]    j2_q, j2_d;
`ifdef JOY_DEBOUNCE_EN
  logic [NBITS-1:0] prv, prv_d;
`endif

  logic tick;
  logic div_ce_c;
  logic last_bit_c;

  // DONE must not advance the divider; it was just cleared by the final tick
  assign div_ce_c   = ce & (state != DONE);
  assign last_bit_c = (bit_q == BW'(NBITS - 1));

  joy_tick #(.CKDIV(CKDIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .ce    (div_ce_c),
    .tick  (tick)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= LOAD;
      bit_q  <= '0;
      sr     <= '1;
      ck_q   <= 1'b0;
      ld_q   <= 1'b1;
      strb_q <= 1'b0;
      j1_q   <= RELEASED;
      j2_q   <= RELEASED;
`ifdef JOY_DEBOUNCE_EN
      prv    <= '1;
`endif
    end else begin
      state  <= state_d;
      bit_q  <= bit_d;
      sr     <= sr_d;
      ck_q   <= ck_d;
      ld_q   <= ld_d;
      strb_q <= strb_d;
      j1_q   <= j1_d;
      j2_q   <= j2_d;
`ifdef JOY_DEBOUNCE_EN
      prv    <= prv_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      LOAD:     if (tick) state_d = SHIFT_LO;
      SHIFT_LO: if (tick) state_d = SHIFT_HI;
      SHIFT_HI: if (tick) state_d = last_bit_c ? DONE : SHIFT_LO;
      DONE:     state_d = LOAD;
      default:  state_d = LOAD;
    endcase
  end

  // Next values of registered outputs and datapath
  always_comb begin
    bit_d  = bit_q;
    sr_d   = sr;
    ck_d   = ck_q;
    ld_d   = ld_q;
    strb_d = 1'b0;
    j1_d   = j1_q;
    j2_d   = j2_q;
`ifdef JOY_DEBOUNCE_EN
    prv_d  = prv;
`endif
    case (state)
      LOAD: begin
        // load_n stays low for the whole LOAD phase, rising on its final tick
        if (ce) ld_d = tick;
        if (tick) bit_d = '0;
      end
      SHIFT_LO: begin
        if (tick) begin
          sr_d[bit_q] = bus.joyD;
          ck_d        = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          ck_d = 1'b0;
          if (!last_bit_c) bit_d = bit_q + BW'(1);
        end
      end
      DONE: begin
        strb_d = 1'b1;
        ld_d   = 1'b0;
`ifdef JOY_DEBOUNCE_EN
        if (sr == prv) begin
          j1_d = sr[J1_LSB +: JW];
          j2_d = sr[J2_LSB +: JW];
        end
        prv_d = sr;
`else
        j1_d = sr[J1_LSB +: JW];
        j2_d = sr[J2_LSB +: JW];
`endif
      end
      default: ;
    endcase
  end

  assign bus.joyCk = ck_q;
  assign bus.joyLd = ld_q;
  assign bus.joy1  = j1_q;
  assign bus.joy2  = j2_q;
  assign bus.strb  = strb_q;

endmodule

// File: tb/tb_joy_serial.sv
// Bench for joy_serial: a behavioural shift-register model feeds frames,
// and a frame-level reference model predicts joy1/joy2 after each strobe.
`timescale 1ns/1ps
module tb_joy_serial;
  import joy_pkg::*;

  localparam int unsigned CKDIV = 4;
  localparam int unsigned NBITS = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b0;

  int checks = 0;
  int errors = 0;

  joy_serial_if jif ();

  joy_serial #(.CKDIV(CKDIV), .NBITS(NBITS)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .bus   (jif)
  );

  always #5 clock = ~clock;

  // ce generator: one ce every ce_div clocks
  int unsigned ce_div = 1;
  int unsigned ce_cnt = 0;
  always @(negedge clock) begin
    ce_cnt = (ce_cnt + 1) % ce_div;
    ce     = (ce_cnt == 0);
  end

  // External shift register: captures 'frame' while load_n is low,
  // advances one position per rising joyCk, reads 1 once exhausted.
  logic [15:0] frame = 16'hFFFF;
  logic [15:0] held  = 16'hFFFF;
  logic [4:0]  pos   = 5'd16;
  logic        ck_m  = 1'b0;
  always @(posedge clock) begin
    if (!jif.joyLd) begin
      held <= frame;
      pos  <= 5'd0;
    end else if (jif.joyCk && !ck_m) begin
      pos <= pos + 5'd1;
    end
    ck_m <= jif.joyCk;
  end
  assign jif.joyD = pos[4] ? 1'b1 : held[pos[3:0]];

  // Frame-level reference model
  logic [5:0]  exp1, exp2;
  logic [15:0] mprv;

  task automatic model_reset();
    exp1 = 6'h3F;
    exp2 = 6'h3F;
    mprv = 16'hFFFF;
  endtask

  task automatic model_frame(input logic [15:0] f);
`ifdef JOY_DEBOUNCE_EN
    if (f == mprv) begin
      exp1 = f[5:0];
      exp2 = f[13:8];
    end
    mprv = f;
`else
    exp1 = f[5:0];
    exp2 = f[13:8];
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Supply one frame and follow it to its strobe, checking timing and decode
  task automatic run_frame(input logic [15:0] f);
    int   cyc, rises, hi, ldlow;
    logic ckp, seen;
    frame = f;
    cyc = 0; rises = 0; hi = 0; ldlow = 0;
    ckp = jif.joyCk;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (jif.joyCk && !ckp) rises++;
      if (jif.joyCk) hi++;
      if (!jif.joyLd) ldlow++;
      ckp  = jif.joyCk;
      seen = jif.strb;
    end
    chk("strb_seen", 32'(seen), 32'd1);
    model_frame(f);
    chk("joy1", 32'(jif.joy1), 32'(exp1));
    chk("joy2", 32'(jif.joy2), 32'(exp2));
    chk("ck_pulses", 32'(rises), 32'd16);
    chk("ck_high_clocks", 32'(hi), 32'(16 * CKDIV * ce_div));
    if (ce_div == 1) begin
      chk("frame_clocks", 32'(cyc), 32'd133);
      chk("ld_low_clocks", 32'(ldlow), 32'(CKDIV));
    end
  endtask

  initial begin
    logic [15:0] r;
    int   n, cnt;
    logic ckp;

    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_joyCk", 32'(jif.joyCk), 32'd0);
    chk("rst_joyLd", 32'(jif.joyLd), 32'd1);
    chk("rst_joy1", 32'(jif.joy1), 32'h3F);
    chk("rst_joy2", 32'(jif.joy2), 32'h3F);
    chk("rst_strb", 32'(jif.strb), 32'd0);
    reset = 1'b1;

    // Nothing connected
    repeat (3) run_frame(16'hFFFF);

    // Single button and two-button frames
    run_frame(16'hFFFE);
    run_frame(16'hEFEF);

    // Random frames, each sent twice so debounce also commits
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      run_frame(r);
      run_frame(r);
    end

    // Debounce sequence A, B, A, A
    run_frame(16'hFFFE);
    run_frame(16'hFFFF);
    run_frame(16'hFFFE);
    run_frame(16'hFFFE);

    // Reset in the middle of a frame carrying bit3 = 0
    run_frame(16'hFFF7);
    run_frame(16'hFFF7);
    frame = 16'hFFF7;
    n = 0; cnt = 0;
    ckp = jif.joyCk;
    while (n < 9 && cnt < 2000) begin
      @(negedge clock);
      cnt++;
      if (jif.joyCk && !ckp) n++;
      ckp = jif.joyCk;
    end
    chk("reach_bit9", 32'(n), 32'd9);
    reset = 1'b0;
    #1;
    chk("midrst_joy1", 32'(jif.joy1), 32'h3F);
    chk("midrst_joy2", 32'(jif.joy2), 32'h3F);
    chk("midrst_joyLd", 32'(jif.joyLd), 32'd1);
    chk("midrst_joyCk", 32'(jif.joyCk), 32'd0);
    chk("midrst_strb", 32'(jif.strb), 32'd0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    run_frame(16'hFFF7);

    // Slow clock enable: one ce in eight
    ce_div = 8;
    run_frame(16'hFFFE);
    r = 16'($urandom);
    run_frame(r);
    run_frame(r);

    // Strobe lasts a single clock
    @(negedge clock);
    chk("strb_single", 32'(jif.strb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
